// File: rtl/vec_issue_seq_if.sv
// Bundle for vec_issue_seq: decode-side op handshake plus the four-lane beat bus.
// The sequencer connects through the slave modport; the decode/lane environment uses master.
interface vec_issue_seq_if;
    logic         in_valid;
    logic         in_ready;
    logic [2:0]   in_op;
    logic [3:0]   in_rt;
    logic [255:0] in_va;
    logic [255:0] in_vb;
    logic [4:0]   in_vl;

    logic [3:0]   lane_valid;
    logic         lane_ready;
    logic [2:0]   lane_op;
    logic [3:0]   lane_rt;
    logic [1:0]   lane_beat;
    logic [63:0]  lane_a;
    logic [63:0]  lane_b;
    logic         lane_last;

    modport slave (
        input  in_valid, in_op, in_rt, in_va, in_vb, in_vl, lane_ready,
        output in_ready, lane_valid, lane_op, lane_rt, lane_beat, lane_a, lane_b, lane_last
    );

    modport master (
        output in_valid, in_op, in_rt, in_va, in_vb, in_vl, lane_ready,
        input  in_ready, lane_valid, lane_op, lane_rt, lane_beat, lane_a, lane_b, lane_last
    );
endinterface

// File: rtl/vec_issue_seq.sv
// Vector issue sequencer: splits a 16-element op into 4-element beats for four lanes.
// Optional macro VEC_VL_EN enables length-controlled issue from in_vl.
module vec_issue_seq (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           flush,
    vec_issue_seq_if.slave bus
);
    typedef enum logic {IDLE, ISSUE} state_t;

    state_t         state_q, state_d;
    logic [1:0]     k_q, k_d;
    logic [4:0]     vl_q, vl_d;
    logic [255:0]   va_q, va_d;
    logic [255:0]   vb_q, vb_d;
    logic [2:0]     lane_op_q, lane_op_d;
    logic [3:0]     lane_rt_q, lane_rt_d;
    logic [1:0]     lane_beat_q, lane_beat_d;
    logic [3:0]     lane_valid_q, lane_valid_d;
    logic           lane_last_q, lane_last_d;
    logic [63:0]    lane_a_q, lane_a_d;
    logic [63:0]    lane_b_q, lane_b_d;

    logic [4:0]     in_vl_eff;
    logic           accept;

    function automatic logic [3:0] beat_mask(input logic [1:0] k, input logic [4:0] vl);
        logic [3:0] m;
        for (int i = 0; i < 4; i++) begin
            m[i] = (({1'b0, k, 2'b00} + 5'(i)) < vl);
        end
        return m;
    endfunction

    // Index of the final beat; only meaningful for vl >= 1.
    function automatic logic [1:0] last_beat(input logic [4:0] vl);
        return 2'((vl - 5'd1) >> 2);
    endfunction

    function automatic logic [63:0] slice64(input logic [255:0] v, input logic [1:0] k);
        return v[{k, 6'd0} +: 64];
    endfunction

    always_comb begin
`ifdef VEC_VL_EN
        in_vl_eff = (bus.in_vl > 5'd16) ? 5'd16 : bus.in_vl;
`else
        // Length input is deliberately ignored: every op is a full 16 elements.
        in_vl_eff = 5'd16 | (bus.in_vl & 5'd0);
`endif
    end

    assign bus.in_ready = rst_n && !flush &&
                          ((state_q == IDLE) || (state_q == ISSUE && lane_last_q && bus.lane_ready));
    assign accept       = bus.in_valid && bus.in_ready;

    always_comb begin
        state_d      = state_q;
        k_d          = k_q;
        vl_d         = vl_q;
        va_d         = va_q;
        vb_d         = vb_q;
        lane_op_d    = lane_op_q;
        lane_rt_d    = lane_rt_q;
        lane_beat_d  = lane_beat_q;
        lane_valid_d = lane_valid_q;
        lane_last_d  = lane_last_q;
        lane_a_d     = lane_a_q;
        lane_b_d     = lane_b_q;

        if (flush) begin
            state_d      = IDLE;
            k_d          = 2'd0;
            lane_valid_d = 4'd0;
            lane_last_d  = 1'b0;
        end else begin
            if (state_q == ISSUE && bus.lane_ready) begin
                if (lane_last_q) begin
                    state_d      = IDLE;
                    k_d          = 2'd0;
                    lane_valid_d = 4'd0;
                    lane_last_d  = 1'b0;
                end else begin
                    k_d          = k_q + 2'd1;
                    lane_beat_d  = k_d;
                    lane_valid_d = beat_mask(k_d, vl_q);
                    lane_last_d  = (k_d == last_beat(vl_q));
                    lane_a_d     = slice64(va_q, k_d);
                    lane_b_d     = slice64(vb_q, k_d);
                end
            end

            // An accept on the final beat overrides the return to IDLE (no bubble).
            if (accept) begin
                va_d = bus.in_va;
                vb_d = bus.in_vb;
                vl_d = in_vl_eff;
                k_d  = 2'd0;
                if (in_vl_eff == 5'd0) begin
                    state_d      = IDLE;
                    lane_valid_d = 4'd0;
                    lane_last_d  = 1'b0;
                end else begin
                    state_d      = ISSUE;
                    lane_op_d    = bus.in_op;
                    lane_rt_d    = bus.in_rt;
                    lane_beat_d  = 2'd0;
                    lane_valid_d = beat_mask(2'd0, in_vl_eff);
                    lane_last_d  = (last_beat(in_vl_eff) == 2'd0);
                    lane_a_d     = bus.in_va[63:0];
                    lane_b_d     = bus.in_vb[63:0];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            k_q          <= 2'd0;
            vl_q         <= 5'd0;
            va_q         <= '0;
            vb_q         <= '0;
            lane_op_q    <= 3'd0;
            lane_rt_q    <= 4'd0;
            lane_beat_q  <= 2'd0;
            lane_valid_q <= 4'd0;
            lane_last_q  <= 1'b0;
            lane_a_q     <= 64'd0;
            lane_b_q     <= 64'd0;
        end else begin
            state_q      <= state_d;
            k_q          <= k_d;
            vl_q         <= vl_d;
            va_q         <= va_d;
            vb_q         <= vb_d;
            lane_op_q    <= lane_op_d;
            lane_rt_q    <= lane_rt_d;
            lane_beat_q  <= lane_beat_d;
            lane_valid_q <= lane_valid_d;
            lane_last_q  <= lane_last_d;
            lane_a_q     <= lane_a_d;
            lane_b_q     <= lane_b_d;
        end
    end

    assign bus.lane_valid = lane_valid_q;
    assign bus.lane_last  = lane_last_q;
    assign bus.lane_op    = lane_op_q;
    assign bus.lane_rt    = lane_rt_q;
    assign bus.lane_beat  = lane_beat_q;
    assign bus.lane_a     = lane_a_q;
    assign bus.lane_b     = lane_b_q;
endmodule

// File: tb/tb_vec_issue_seq.sv
// Bench for vec_issue_seq: directed scenarios then random traffic, checked against an
// element-level model of the op in flight. Define VEC_VL_EN to exercise length control.
`timescale 1ns/1ps
module tb_vec_issue_seq;
    logic clk = 1'b0;
    logic rst_n;
    logic flush;

    vec_issue_seq_if bus();

    vec_issue_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: the op in flight as element arrays plus the current beat number.
    bit          m_busy = 1'b0;
    int          m_k    = 0;
    int          m_vl   = 16;
    logic [2:0]  m_op   = 3'd0;
    logic [3:0]  m_rt   = 4'd0;
    logic [15:0] m_ea [16];
    logic [15:0] m_eb [16];

    logic [255:0] g_va, g_vb;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int w = 0; w < 8; w++) r[32*w +: 32] = $urandom;
        return r;
    endfunction

    function automatic int eff_vl(input logic [4:0] vl);
`ifdef VEC_VL_EN
        return (int'(vl) > 16) ? 16 : int'(vl);
`else
        return 16;
`endif
    endfunction

    // One clock cycle: drive at negedge, compare against the model, then advance the model.
    task automatic cyc(input logic rn, input logic fl, input logic iv, input logic [2:0] op,
                       input logic [3:0] rt, input logic [4:0] vl, input logic lr);
        logic [3:0]  e_valid;
        logic        e_last, e_ready;
        logic [63:0] ea, eb;
        int          nb;
        @(negedge clk);
        rst_n = rn; flush = fl;
        bus.in_valid = iv; bus.in_op = op; bus.in_rt = rt; bus.in_vl = vl;
        bus.in_va = g_va; bus.in_vb = g_vb; bus.lane_ready = lr;
        #1;
        e_valid = 4'd0; e_last = 1'b0; ea = 64'd0; eb = 64'd0;
        if (m_busy) begin
            nb = (m_vl + 3) / 4;
            for (int i = 0; i < 4; i++) begin
                e_valid[i]      = (4*m_k + i < m_vl);
                ea[16*i +: 16]  = m_ea[4*m_k + i];
                eb[16*i +: 16]  = m_eb[4*m_k + i];
            end
            e_last = (m_k == nb - 1);
        end
        e_ready = rn && !fl && (!m_busy || (e_last && lr));
        chk("in_ready",   64'(bus.in_ready),   64'(e_ready));
        chk("lane_valid", 64'(bus.lane_valid), 64'(e_valid));
        chk("lane_last",  64'(bus.lane_last),  64'(e_last));
        if (m_busy) begin
            chk("lane_op",   64'(bus.lane_op),   64'(m_op));
            chk("lane_rt",   64'(bus.lane_rt),   64'(m_rt));
            chk("lane_beat", 64'(bus.lane_beat), 64'(m_k));
            chk("lane_a",    bus.lane_a, ea);
            chk("lane_b",    bus.lane_b, eb);
        end
        if (!rn || fl) begin
            m_busy = 1'b0;
            m_k    = 0;
        end else if (iv && e_ready) begin
            for (int e = 0; e < 16; e++) begin
                m_ea[e] = g_va[16*e +: 16];
                m_eb[e] = g_vb[16*e +: 16];
            end
            m_vl   = eff_vl(vl);
            m_busy = (m_vl != 0);
            m_k    = 0;
            m_op   = op;
            m_rt   = rt;
        end else if (m_busy && lr) begin
            if (e_last) m_busy = 1'b0;
            else        m_k++;
        end
    endtask

    initial begin
        int cnt;
        rst_n = 1'b0; flush = 1'b0;
        bus.in_valid = 1'b0; bus.in_op = 3'd0; bus.in_rt = 4'd0; bus.in_vl = 5'd16;
        bus.in_va = '0; bus.in_vb = '0; bus.lane_ready = 1'b1;
        g_va = '0; g_vb = '0;

        // Reset state
        cyc(0, 0, 0, 0, 0, 16, 1);
        cyc(0, 0, 1, 0, 0, 16, 1);
        chk("rst_lane_a",    bus.lane_a, 64'd0);
        chk("rst_lane_b",    bus.lane_b, 64'd0);
        chk("rst_lane_op",   64'(bus.lane_op), 64'd0);
        chk("rst_lane_beat", 64'(bus.lane_beat), 64'd0);
        cyc(1, 0, 0, 0, 0, 16, 1);

        // Basic vadd, rt=3, elements 0x0100+e
        for (int e = 0; e < 16; e++) g_va[16*e +: 16] = 16'h0100 + 16'(e);
        g_vb = rand256();
        cyc(1, 0, 1, 3'd0, 4'd3, 16, 1);
        for (int b = 0; b < 4; b++) begin
            cyc(1, 0, 0, 3'd0, 4'd3, 16, 1);
            chk("basic_beat", 64'(bus.lane_beat), 64'(b));
            chk("basic_last", 64'(bus.lane_last), 64'(b == 3));
            if (b == 2) chk("basic_b2_lane_a", bus.lane_a, 64'h010B_010A_0109_0108);
            if (b == 3) chk("basic_b3_in_ready", 64'(bus.in_ready), 64'd1);
        end
        cyc(1, 0, 0, 0, 0, 16, 1);
        chk("basic_idle_valid", 64'(bus.lane_valid), 64'd0);

        // Back-to-back vmul then vsub with in_valid held
        g_va = rand256(); g_vb = rand256();
        cyc(1, 0, 1, 3'd2, 4'd5, 16, 1);
        g_va = rand256(); g_vb = rand256();
        for (int c = 0; c < 8; c++) begin
            cyc(1, 0, (c < 4), 3'd1, 4'd6, 16, 1);
            chk("b2b_valid", 64'(bus.lane_valid), 64'hF);
            chk("b2b_beat",  64'(bus.lane_beat), 64'(c % 4));
            chk("b2b_op",    64'(bus.lane_op), (c < 4) ? 64'd2 : 64'd1);
        end
        cyc(1, 0, 0, 0, 0, 16, 1);
        chk("b2b_idle_valid", 64'(bus.lane_valid), 64'd0);

        // Lane backpressure for 3 cycles during beat 1
        g_va = rand256(); g_vb = rand256();
        cyc(1, 0, 1, 3'd3, 4'd1, 16, 1);
        cnt = 0;
        for (int c = 0; c < 10; c++) begin
            cyc(1, 0, 0, 0, 0, 16, !(c >= 1 && c <= 3));
            if (bus.lane_valid != 4'd0) cnt++;
            if (c >= 1 && c <= 4) chk("bp_hold_beat", 64'(bus.lane_beat), 64'd1);
        end
        chk("bp_cycles", 64'(cnt), 64'd7);

        // Flush during beat 2, new op next cycle
        g_va = rand256(); g_vb = rand256();
        cyc(1, 0, 1, 3'd4, 4'd2, 16, 1);
        cyc(1, 0, 0, 0, 0, 16, 1);
        cyc(1, 0, 0, 0, 0, 16, 1);
        cyc(1, 1, 1, 3'd5, 4'd7, 16, 1);
        chk("flush_in_ready", 64'(bus.in_ready), 64'd0);
        chk("flush_beat", 64'(bus.lane_beat), 64'd2);
        g_va = rand256(); g_vb = rand256();
        cyc(1, 0, 1, 3'd5, 4'd7, 16, 1);
        chk("flush_next_valid", 64'(bus.lane_valid), 64'd0);
        cyc(1, 0, 0, 0, 0, 16, 1);
        chk("flush_restart_beat", 64'(bus.lane_beat), 64'd0);
        chk("flush_restart_op", 64'(bus.lane_op), 64'd5);
        for (int c = 0; c < 4; c++) cyc(1, 0, 0, 0, 0, 16, 1);

        // Reset during beat 1
        g_va = rand256(); g_vb = rand256();
        cyc(1, 0, 1, 3'd7, 4'd9, 16, 1);
        cyc(1, 0, 0, 0, 0, 16, 1);
        cyc(0, 0, 0, 0, 0, 16, 1);
        cyc(0, 0, 1, 0, 0, 16, 1);
        chk("rst_mid_in_ready", 64'(bus.in_ready), 64'd0);
        chk("rst_mid_lane_a",   bus.lane_a, 64'd0);
        chk("rst_mid_lane_rt",  64'(bus.lane_rt), 64'd0);
        chk("rst_mid_valid",    64'(bus.lane_valid), 64'd0);
        g_va = rand256(); g_vb = rand256();
        cyc(1, 0, 1, 3'd6, 4'd4, 16, 1);
        for (int c = 0; c < 5; c++) cyc(1, 0, 0, 0, 0, 16, 1);

`ifdef VEC_VL_EN
        g_va = rand256(); g_vb = rand256();
        cyc(1, 0, 1, 3'd0, 4'd1, 5'd6, 1);
        cyc(1, 0, 0, 0, 0, 16, 1);
        cyc(1, 0, 0, 0, 0, 16, 1);
        chk("vl6_beat1_valid", 64'(bus.lane_valid), 64'h3);
        chk("vl6_beat1_last",  64'(bus.lane_last), 64'd1);
        cyc(1, 0, 0, 0, 0, 16, 1);
        chk("vl6_done", 64'(bus.lane_valid), 64'd0);
        cyc(1, 0, 1, 3'd0, 4'd1, 5'd0, 1);
        cyc(1, 0, 0, 0, 0, 16, 1);
        chk("vl0_in_ready", 64'(bus.in_ready), 64'd1);
        chk("vl0_valid",    64'(bus.lane_valid), 64'd0);
        cyc(1, 0, 1, 3'd0, 4'd1, 5'd20, 1);
        cnt = 0;
        for (int c = 0; c < 6; c++) begin
            cyc(1, 0, 0, 0, 0, 16, 1);
            if (bus.lane_valid == 4'hF) cnt++;
        end
        chk("vl20_beats", 64'(cnt), 64'd4);
`endif

        // Random traffic
        for (int c = 0; c < 600; c++) begin
            g_va = rand256(); g_vb = rand256();
            cyc(($urandom_range(99) != 0), ($urandom_range(29) == 0), ($urandom_range(9) < 6),
                3'($urandom_range(7)), 4'($urandom_range(15)), 5'($urandom_range(20)),
                ($urandom_range(9) < 7));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
